nibble_serial_adder: RTL and testbench

//   Multi-cycle WIDTH-bit adder front end that drives a 4-bit ripple adder slice one nibble per cycle.
//   The slice is four full-adder cells inside this block: SUM = A^B^Cin, Cout = majority.

---
 rtl/nibble_serial_adder_if.sv | 29 ++
 rtl/nibble_serial_adder.sv | 154 +++++++++++++++
 tb/tb_nibble_serial_adder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if: operand/result bundle for nibble_serial_adder.
//   master: operand source / result consumer (drives start, A, B, Cin)
//   slave : the adder (drives busy, done, SUM, Cout and, with OVF_DETECT_EN, V)
//   start  request, sampled only while the adder is idle
//   A, B   WIDTH-bit operands, Cin carry-in (captured with start)
//   busy   high while an add is in flight or completing
//   done   one-cycle pulse, SUM/Cout (and V) valid
//   SUM    WIDTH-bit result, Cout final carry, V signed overflow (optional)
interface nibble_serial_adder_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] SUM;
   logic             Cout;
`ifdef OVF_DETECT_EN
   logic             V;

   modport master (output start, A, B, Cin, input busy, done, SUM, Cout, V);
   modport slave  (input start, A, B, Cin, output busy, done, SUM, Cout, V);
`else
   modport master (output start, A, B, Cin, input busy, done, SUM, Cout);
   modport slave  (input start, A, B, Cin, output busy, done, SUM, Cout);
`endif
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle WIDTH-bit adder that pushes one nibble per
// cycle through a 4-bit ripple slice built from four full-adder cells, carrying
// between nibbles through a registered carry.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  nibble_serial_adder_if.slave (start/A/B/Cin in, busy/done/SUM/Cout out)
// Optional feature macro: OVF_DETECT_EN adds the signed-overflow output V.
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder #(
   parameter int unsigned WIDTH = 16
) (
   input logic                   clk,
   input logic                   rst,
   nibble_serial_adder_if.slave  bus
);

   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   // Reject unsupported widths at elaboration
   generate
      if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
         $error("nibble_serial_adder: WIDTH must be a multiple of 4 and >= 4");
      end
   endgenerate

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic             carry_q, carry_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef OVF_DETECT_EN
   logic             v_q, v_d;
`endif

   logic [3:0] nib_a;
   logic [3:0] nib_b;
   logic [3:0] nib_s;
   logic [4:0] c;

   // 4-bit ripple slice on the currently selected nibble; c[3] is the carry
   // into the nibble MSB, c[4] the carry out of it
   always_comb begin
      nib_a = opa_q[{idx_q, 2'b00} +: 4];
      nib_b = opb_q[{idx_q, 2'b00} +: 4];
      nib_s = '0;
      c     = '0;
      c[0]  = carry_q;
      for (int j = 0; j < 4; j++) begin
         nib_s[j]  = nib_a[j] ^ nib_b[j] ^ c[j];
         c[j+1]    = (nib_a[j] & nib_b[j]) | (nib_a[j] & c[j]) | (nib_b[j] & c[j]);
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef OVF_DETECT_EN
      v_d     = v_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               opa_d   = bus.A;
               opb_d   = bus.B;
               carry_d = bus.Cin;
               idx_d   = '0;
`ifdef OVF_DETECT_EN
               v_d     = 1'b0;
`endif
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[{idx_q, 2'b00} +: 4] = nib_s;
            carry_d = c[4];
            if (idx_q == LAST_IDX) begin
               cout_d  = c[4];
`ifdef OVF_DETECT_EN
               v_d     = c[3] ^ c[4];
`endif
               idx_d   = '0;
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef OVF_DETECT_EN
         v_q     <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef OVF_DETECT_EN
         v_q     <= v_d;
`endif
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.SUM  = sum_q;
   assign bus.Cout = cout_q;
`ifdef OVF_DETECT_EN
   assign bus.V    = v_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder: directed vectors plus corner sequences for the
// nibble-serial adder at WIDTH=16, and a short sequence at WIDTH=4.
module tb_nibble_serial_adder;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   nibble_serial_adder_if #(.WIDTH(16)) bus16 ();
   nibble_serial_adder_if #(.WIDTH(4))  bus4 ();

   nibble_serial_adder #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));
   nibble_serial_adder #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic [15:0] sum;
      logic        cout;
      logic        v;
   } vec_t;

   vec_t vecs [12];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one 16-bit add from idle; returns at the negedge where done is high.
   // lat counts negedges after the accepting edge (0 = done never seen).
   task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       output int lat, output logic busy_ok);
      @(negedge clk);
      bus16.A = a; bus16.B = b; bus16.Cin = cin; bus16.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus16.start = 1'b0;
      lat = 1;
      busy_ok = bus16.busy;
      while (!bus16.done && lat < 40) begin
         @(negedge clk);
         lat++;
         busy_ok &= bus16.busy;
      end
      if (!bus16.done) lat = 0;
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin, output int lat);
      @(negedge clk);
      bus4.A = a; bus4.B = b; bus4.Cin = cin; bus4.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus4.start = 1'b0;
      lat = 1;
      while (!bus4.done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      if (!bus4.done) lat = 0;
   endtask

   initial begin
      int          lat;
      logic        bok;
      int          ndone;
      int          done_cyc;
      logic [15:0] cap_sum;
      logic        cap_cout;
      logic [3:0]  a4, b4;
      logic        c4;
      logic [4:0]  e4;
      logic [15:0] a16, b16;
      logic        c16;
      logic [16:0] e16;

      //            a         b         cin   sum       cout  v
      vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[1]  = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
      vecs[2]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
      vecs[3]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
      vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[5]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
      vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[7]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[8]  = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
      vecs[9]  = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};
      vecs[10] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
      vecs[11] = '{16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, 1'b0};

      rst = 1'b1;
      bus16.start = 1'b0; bus16.A = '0; bus16.B = '0; bus16.Cin = 1'b0;
      bus4.start  = 1'b0; bus4.A  = '0; bus4.B  = '0; bus4.Cin  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus16.busy), 0);
      check("rst_done", 32'(bus16.done), 0);
      check("rst_sum",  32'(bus16.SUM),  0);
      check("rst_cout", 32'(bus16.Cout), 0);
`ifdef OVF_DETECT_EN
      check("rst_v", 32'(bus16.V), 0);
`endif
      rst = 1'b0;
      @(negedge clk);
      check("idle_busy", 32'(bus16.busy), 0);

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         op16(vecs[i].a, vecs[i].b, vecs[i].cin, lat, bok);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
         check($sformatf("v%0d_sum", i), 32'(bus16.SUM), 32'(vecs[i].sum));
         check($sformatf("v%0d_cout", i), 32'(bus16.Cout), 32'(vecs[i].cout));
         check($sformatf("v%0d_busy_run", i), 32'(bok), 1);
`ifdef OVF_DETECT_EN
         check($sformatf("v%0d_v", i), 32'(bus16.V), 32'(vecs[i].v));
`endif
         @(negedge clk);
         check($sformatf("v%0d_done_pulse", i), 32'(bus16.done), 0);
         check($sformatf("v%0d_busy_after", i), 32'(bus16.busy), 0);
         check($sformatf("v%0d_sum_held", i), 32'(bus16.SUM), 32'(vecs[i].sum));
      end

      // Back-to-back with start held high: second op accepted on the first idle edge
      @(negedge clk);
      bus16.A = 16'h1234; bus16.B = 16'h4321; bus16.Cin = 1'b1; bus16.start = 1'b1;
      @(posedge clk);
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus16.done && lat < 40);
      check("b2b_first_latency", 32'(lat), 32'd5);
      check("b2b_first_sum", 32'(bus16.SUM), 32'h5556);
      bus16.A = 16'h0FFF; bus16.B = 16'h0001; bus16.Cin = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (lat == 2) bus16.start = 1'b0;
      end while (!bus16.done && lat < 40);
      bus16.start = 1'b0;
      check("b2b_second_spacing", 32'(lat), 32'd6);
      check("b2b_second_sum", 32'(bus16.SUM), 32'h1000);
      check("b2b_second_cout", 32'(bus16.Cout), 0);
      repeat (2) @(negedge clk);

      // start pulsed during RUN (cycle 2) and DONE (cycle 5) is ignored
      @(negedge clk);
      bus16.A = 16'h0001; bus16.B = 16'h0001; bus16.Cin = 1'b0; bus16.start = 1'b1;
      @(posedge clk);
      ndone = 0; done_cyc = 0; cap_sum = '0; cap_cout = 1'b0;
      for (int cyc = 1; cyc <= 14; cyc++) begin
         @(negedge clk);
         if (bus16.done) begin
            ndone++;
            done_cyc = cyc;
            cap_sum  = bus16.SUM;
            cap_cout = bus16.Cout;
         end
         if (cyc == 2 || cyc == 5) begin
            bus16.A = 16'hFFFF; bus16.B = 16'hFFFF; bus16.Cin = 1'b1; bus16.start = 1'b1;
         end else begin
            bus16.start = 1'b0;
         end
      end
      check("ign_done_count", 32'(ndone), 1);
      check("ign_done_cycle", 32'(done_cyc), 5);
      check("ign_sum", 32'(cap_sum), 32'h0002);
      check("ign_cout", 32'(cap_cout), 0);

      // Asynchronous reset in cycle 3 of an add discards it
      @(negedge clk);
      bus16.A = 16'h1234; bus16.B = 16'h4321; bus16.Cin = 1'b1; bus16.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus16.start = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(bus16.busy), 0);
      check("mid_rst_done", 32'(bus16.done), 0);
      check("mid_rst_sum",  32'(bus16.SUM),  0);
      check("mid_rst_cout", 32'(bus16.Cout), 0);
      @(negedge clk);
      rst = 1'b0;
      ndone = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
         @(negedge clk);
         if (bus16.done) ndone++;
      end
      check("mid_rst_no_done", 32'(ndone), 0);
      op16(16'hABCD, 16'h1234, 1'b1, lat, bok);
      check("post_rst_latency", 32'(lat), 32'd5);
      check("post_rst_sum", 32'(bus16.SUM), 32'hBE02);
      check("post_rst_cout", 32'(bus16.Cout), 0);
      @(negedge clk);

`ifdef OVF_DETECT_EN
      // V is cleared as soon as the next add is accepted
      op16(16'h7FFF, 16'h0001, 1'b0, lat, bok);
      check("ovf_set", 32'(bus16.V), 1);
      @(negedge clk);
      check("ovf_held", 32'(bus16.V), 1);
      op16(16'h0001, 16'h0001, 1'b0, lat, bok);
      check("ovf_clear_sum", 32'(bus16.SUM), 32'h0002);
      check("ovf_clear", 32'(bus16.V), 0);
      @(negedge clk);
`endif

      // Random 16-bit regression against plain addition
      for (int k = 0; k < 8; k++) begin
         a16 = 16'($urandom);
         b16 = 16'($urandom);
         c16 = 1'($urandom_range(0, 1));
         e16 = {1'b0, a16} + {1'b0, b16} + {16'b0, c16};
         op16(a16, b16, c16, lat, bok);
         check($sformatf("rnd16_%0d", k), 32'({bus16.Cout, bus16.SUM}), 32'(e16));
         @(negedge clk);
      end

      // WIDTH=4: single nibble, done two cycles after start
      op4(4'hF, 4'h1, 1'b1, lat);
      check("w4_latency", 32'(lat), 32'd2);
      check("w4_sum", 32'(bus4.SUM), 32'h1);
      check("w4_cout", 32'(bus4.Cout), 1);
      @(negedge clk);
      check("w4_done_pulse", 32'(bus4.done), 0);
      for (int k = 0; k < 16; k++) begin
         a4 = 4'($urandom_range(0, 15));
         b4 = 4'($urandom_range(0, 15));
         c4 = 1'($urandom_range(0, 1));
         e4 = {1'b0, a4} + {1'b0, b4} + {4'b0, c4};
         op4(a4, b4, c4, lat);
         check($sformatf("rnd4_%0d", k), 32'({bus4.Cout, bus4.SUM}), 32'(e4));
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
